// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard controller.
// Forward selects follow the E-stage operand mux input order.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  // M beats W because it holds the younger producer.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       rw_m,
    input logic [4:0] wr_m,
    input logic       rw_w,
    input logic [4:0] wr_w
  );
    fwd_sel = FWD_RF;
    if (src != 5'd0) begin
      if (rw_m && wr_m == src)
        fwd_sel = FWD_MEM;
      else if (rw_w && wr_w == src)
        fwd_sel = FWD_WB;
    end
  endfunction

endpackage

// File: rtl/div_stall_ctrl.sv
// Holds the pipeline while a multi-cycle divide sits in E.
// Counts down the remaining stalled cycles of the divide.
module div_stall_ctrl
  import hazard_unit_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_e,
  output logic div_start,
  output logic div_stall
);

  localparam logic [5:0] CNT_INIT = 6'(DIV_LATENCY - 2);

  div_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    div_stall = 1'b0;
    if (!rst) begin
      case (state_q)
        DIV_IDLE: begin
          if (div_e) begin
            div_start = 1'b1;
            div_stall = 1'b1;
            state_d   = DIV_BUSY;
            cnt_d     = CNT_INIT;
          end
        end
        DIV_BUSY: begin
          // Last cycle in E: release stalls.
          if (cnt_q != 6'd0) begin
            div_stall = 1'b1;
            cnt_d     = cnt_q - 6'd1;
          end else begin
            state_d = DIV_IDLE;
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding, load-use/branch stalls and divide hold
// for the five-stage pipeline.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       div_e,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       flush_e,
  output logic       flush_m,
  output logic       div_start,
  output logic       div_busy
);

  logic div_stall;
  logic lw_stall;
  logic br_stall;
  logic hit_e;
  logic hit_m;
  logic any_stall;

  div_stall_ctrl #(
    .DIV_LATENCY(DIV_LATENCY)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .div_e    (div_e),
    .div_start(div_start),
    .div_stall(div_stall)
  );

  assign forward_a_e = fwd_sel(rs_e, reg_write_m, write_reg_m,
                               reg_write_w, write_reg_w);
  assign forward_b_e = fwd_sel(rt_e, reg_write_m, write_reg_m,
                               reg_write_w, write_reg_w);

  assign forward_a_d = (rs_d != 5'd0) && reg_write_m
                    && (write_reg_m == rs_d);
  assign forward_b_d = (rt_d != 5'd0) && reg_write_m
                    && (write_reg_m == rt_d);

  assign hit_e = (write_reg_e != 5'd0)
              && ((write_reg_e == rs_d) || (write_reg_e == rt_d));
  assign hit_m = (write_reg_m != 5'd0)
              && ((write_reg_m == rs_d) || (write_reg_m == rt_d));

  // Reset masks every stall so nothing leaks out while rst is high.
  assign lw_stall = !rst && mem_to_reg_e && hit_e;
  assign br_stall = !rst && branch_d
                 && ((reg_write_e && hit_e) || (mem_to_reg_m && hit_m));

  assign any_stall = div_stall || lw_stall || br_stall;

  assign stall_f  = any_stall;
  assign stall_d  = any_stall;
  assign stall_e  = div_stall;
  assign flush_m  = div_stall;
  assign flush_e  = (lw_stall || br_stall) && !div_stall;
  assign div_busy = div_stall;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized bench for hazard_unit against a cycle-count model.
// Directed cases from the plan run first.
module tb_hazard_unit;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, div_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       forward_a_d, forward_b_d;
  logic       stall_f, stall_d, stall_e;
  logic       flush_e, flush_m;
  logic       div_start, div_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int occ    = 0;

  always #5 clk = ~clk;

  hazard_unit #(.DIV_LATENCY(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .rs_e        (rs_e),
    .rt_e        (rt_e),
    .write_reg_e (write_reg_e),
    .write_reg_m (write_reg_m),
    .write_reg_w (write_reg_w),
    .reg_write_e (reg_write_e),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .mem_to_reg_e(mem_to_reg_e),
    .mem_to_reg_m(mem_to_reg_m),
    .branch_d    (branch_d),
    .div_e       (div_e),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e),
    .forward_a_d (forward_a_d),
    .forward_b_d (forward_b_d),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_e     (stall_e),
    .flush_e     (flush_e),
    .flush_m     (flush_m),
    .div_start   (div_start),
    .div_busy    (div_busy)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_exp(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (reg_write_m && write_reg_m == r) return 2'b10;
    if (reg_write_w && write_reg_w == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic uses(input logic [4:0] w);
    return w != 5'd0 && (w == rs_d || w == rt_d);
  endfunction

  // occ = cycles the divide still holds E, counting this one.
  task automatic step();
    int   eff;
    logic dst, st, lw, br, hz;
    #1;
    eff = (occ == 0 && div_e) ? L : occ;
    dst = !rst && eff > 1;
    st  = !rst && occ == 0 && div_e;
    lw  = !rst && mem_to_reg_e && uses(write_reg_e);
    br  = !rst && branch_d
       && ((reg_write_e && uses(write_reg_e))
        || (mem_to_reg_m && uses(write_reg_m)));
    hz  = lw || br;
    chk("fwd_a_e", 8'(forward_a_e), 8'(fwd_exp(rs_e)));
    chk("fwd_b_e", 8'(forward_b_e), 8'(fwd_exp(rt_e)));
    chk("fwd_a_d", 8'(forward_a_d),
        8'(rs_d != 0 && reg_write_m && write_reg_m == rs_d));
    chk("fwd_b_d", 8'(forward_b_d),
        8'(rt_d != 0 && reg_write_m && write_reg_m == rt_d));
    chk("stall_f", 8'(stall_f), 8'(dst || hz));
    chk("stall_d", 8'(stall_d), 8'(dst || hz));
    chk("stall_e", 8'(stall_e), 8'(dst));
    chk("flush_m", 8'(flush_m), 8'(dst));
    chk("flush_e", 8'(flush_e), 8'(hz && !dst));
    chk("div_busy", 8'(div_busy), 8'(dst));
    chk("div_start", 8'(div_start), 8'(st));
    occ = rst ? 0 : (eff > 0 ? eff - 1 : 0);
    @(negedge clk);
  endtask

  task automatic clear();
    rst = 0; div_e = 0; branch_d = 0;
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0;
  endtask

  task automatic rnd();
    rs_d = 5'($urandom_range(0, 3));
    rt_d = 5'($urandom_range(0, 3));
    rs_e = 5'($urandom_range(0, 3));
    rt_e = 5'($urandom_range(0, 3));
    write_reg_e = 5'($urandom_range(0, 3));
    write_reg_m = 5'($urandom_range(0, 3));
    write_reg_w = 5'($urandom_range(0, 3));
    reg_write_e = 1'($urandom);
    reg_write_m = 1'($urandom);
    reg_write_w = 1'($urandom);
    mem_to_reg_e = 1'($urandom);
    mem_to_reg_m = 1'($urandom);
    branch_d = 1'($urandom);
    div_e = ($urandom_range(0, 4) == 0);
    rst = ($urandom_range(0, 80) == 0);
  endtask

  initial begin
    clear();
    rst = 1;
    @(negedge clk);
    #1 chk("rst_stall_f", 8'(stall_f), 8'd0);
    step();
    rst = 0;

    rs_e = 5; reg_write_m = 1; write_reg_m = 5;
    reg_write_w = 1; write_reg_w = 5;
    #1 chk("fwd_m_prio", 8'(forward_a_e), 8'b10);
    step();
    reg_write_m = 0;
    #1 chk("fwd_w", 8'(forward_a_e), 8'b01);
    step();
    clear();
    reg_write_m = 1; reg_write_w = 1;
    #1 chk("fwd_r0", 8'(forward_a_e), 8'b00);
    step();

    clear();
    mem_to_reg_e = 1; write_reg_e = 8; rt_d = 8;
    #1 chk("lw_flush_e", 8'(flush_e), 8'd1);
    chk("lw_stall_e", 8'(stall_e), 8'd0);
    step();
    write_reg_e = 0; rt_d = 0;
    #1 chk("lw_r0", 8'(stall_d), 8'd0);
    step();

    clear();
    branch_d = 1; reg_write_e = 1; write_reg_e = 3; rs_d = 3;
    #1 chk("br_stall", 8'(stall_d), 8'd1);
    step();
    reg_write_e = 0; write_reg_e = 0;
    reg_write_m = 1; write_reg_m = 3;
    #1 chk("br_fwd_d", 8'(forward_a_d), 8'd1);
    chk("br_nostall", 8'(stall_d), 8'd0);
    step();

    clear();
    div_e = 1;
    for (int c = 0; c < 2 * L; c++) begin
      if (c == 1) begin
        mem_to_reg_e = 1; write_reg_e = 8; rt_d = 8;
      end else begin
        mem_to_reg_e = 0; write_reg_e = 0; rt_d = 0;
      end
      #1;
      chk("div_start_c", 8'(div_start), 8'(c % L == 0));
      chk("div_stall_c", 8'(stall_e), 8'(c % L != L - 1));
      if (c == 1) chk("div_lw_fe", 8'(flush_e), 8'd0);
      step();
    end

    clear();
    div_e = 1;
    step();
    step();
    rst = 1;
    #1 chk("rst_mid", 8'(stall_e), 8'd0);
    step();
    rst = 0; div_e = 0;
    #1 chk("post_rst", 8'(div_busy), 8'd0);
    step();

    for (int i = 0; i < 3000; i++) begin
      rnd();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It sits directly upstream of the E-stage 3-input operand multiplexers and drives their 2-bit select lines (forward_a_e, forward_b_e). It also generates the D-stage branch-compare forwarding selects and the stall/flush controls for F, D, E and M. It owns a small FSM that holds the pipeline while a multi-cycle divide occupies the E stage.

## Interface
Parameters:
- DIV_LATENCY, 32: total cycles a divide occupies E; legal range 2..63.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- rs_d, rt_d  in  5 each  D-stage source registers
- rs_e, rt_e  in  5 each  E-stage source registers
- write_reg_e, write_reg_m, write_reg_w  in  5 each  destination register per stage
- reg_write_e, reg_write_m, reg_write_w  in  1 each  destination write enables
- mem_to_reg_e, mem_to_reg_m  in  1 each  stage holds a load
- branch_d  in  1  D-stage branch/jr needs its operands in D
- div_e  in  1  E-stage instruction is a divide
- forward_a_e, forward_b_e  out  2 each  operand select: 00 = register file, 01 = W-stage result, 10 = M-stage ALU result
- forward_a_d, forward_b_d  out  1 each  D-stage compare select: 1 = M-stage ALU result
- stall_f, stall_d, stall_e  out  1 each  hold the stage register
- flush_e, flush_m  out  1 each  insert a bubble into the stage register
- div_start  out  1  one-cycle start pulse to the divider
- div_busy  out  1  divide stall in progress

## Operation
- Forwarding is combinational. forward_a_e = 10 if rs_e≠0, reg_write_m and write_reg_m==rs_e; else 01 if rs_e≠0, reg_write_w and write_reg_w==rs_e; else 00. M has priority over W. forward_b_e uses the same rule with rt_e.
- forward_a_d = rs_d≠0 & reg_write_m & write_reg_m==rs_d. forward_b_d uses the same rule with rt_d.
- Load-use (lw_stall): mem_to_reg_e & (write_reg_e==rs_d | write_reg_e==rt_d), and write_reg_e≠0.
- Branch stall (br_stall): branch_d & ((reg_write_e & write_reg_e∈{rs_d,rt_d}) | (mem_to_reg_m & write_reg_m∈{rs_d,rt_d})), and the matched register is ≠0.
- Divide FSM, states IDLE and BUSY, with a 6-bit counter cnt:
  - IDLE & div_e: assert div_start, state→BUSY, cnt←DIV_LATENCY−2.
  - BUSY & cnt≠0: cnt←cnt−1.
  - BUSY & cnt==0: state→IDLE. The divide leaves E at the end of this cycle.
- div_stall = (IDLE & div_e) | (BUSY & cnt≠0).
- div_busy = div_stall.
- Output equations:
  - stall_e = div_stall.
  - flush_m = div_stall.
  - stall_f = stall_d = div_stall | lw_stall | br_stall.
  - flush_e = (lw_stall | br_stall) & ~div_stall. A stalled E must never be flushed.

## Timing
- Forward selects and lw/br stalls are valid in the same cycle as their inputs; no registered latency.
- Divide: E is occupied for exactly DIV_LATENCY cycles, and stalls are asserted for the first DIV_LATENCY−1 of them. div_start is high only in the first cycle.
- Back-to-back divides: the cycle after BUSY→IDLE holds a new E instruction. If that instruction is a divide, a fresh sequence starts with a new div_start.
- div_e is sampled only in IDLE. Deassertion of div_e during BUSY is ignored.
- Reset: state=IDLE, cnt=0, div_start=0. Reset forces stall_*, flush_*, div_busy and div_start to 0 regardless of inputs. Forward selects stay combinational. Reset mid-divide abandons the sequence.
- Register 0 never produces a forward or a stall.

## Structure
- Shared package: forward encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; divide FSM state encoding. These encodings must match the E-stage mux select order.
- One sub-module: div_stall_ctrl. It contains the FSM and counter, and outputs div_start and div_stall. Forwarding and lw/br logic stay in the top module.

## Test plan
- rs_e=5, reg_write_m=1, write_reg_m=5, reg_write_w=1, write_reg_w=5 -> forward_a_e=10. Same with reg_write_m=0 -> 01. rs_e=0 with all writes to register 0 -> 00.
- mem_to_reg_e=1, write_reg_e=8, rt_d=8 -> stall_f=stall_d=flush_e=1, stall_e=0. With write_reg_e=0 -> all 0.
- branch_d=1, reg_write_e=1, write_reg_e=rs_d=3 -> br stall. Next cycle with the producer in M as an ALU op (mem_to_reg_m=0) -> no stall, forward_a_d=1.
- DIV_LATENCY=4, div_e held high -> div_start high in cycle 0 only; stall_e=flush_m=1 in cycles 0–2; 0 in cycle 3.
- A load-use hazard coinciding with divide cycle 1 -> flush_e=0, stall_f/d/e=1.
- Two consecutive divides -> div_start in cycle 0 and cycle 4. rst asserted in cycle 2 -> all stalls 0 next cycle; state IDLE.
